// File: rtl/round_final_enc_if.sv
// rtl/round_final_enc_if.sv - handshake/data bundle for the final encryption round
interface round_final_enc_if #(
    parameter int BLOCK_LENGTH = 128
);
    logic [BLOCK_LENGTH-1:0] IN;
    logic [BLOCK_LENGTH-1:0] KEY;
    logic                    in_valid;
    logic                    in_ready;
    logic                    enable;
    logic [BLOCK_LENGTH-1:0] OUT;
    logic                    out_valid;

    modport master (
        output IN, KEY, in_valid, enable,
        input  in_ready, OUT, out_valid
    );

    modport slave (
        input  IN, KEY, in_valid, enable,
        output in_ready, OUT, out_valid
    );
endinterface

// File: rtl/round_final_enc.sv
// rtl/round_final_enc.sv - byte-serial AES final round: SubBytes, ShiftRows, AddRoundKey
module round_final_enc #(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    round_final_enc_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t             state_q;
    logic [127:0]       st_q;
    logic [127:0]       key_q;
    logic [3:0]         cnt_q;
    logic [127:0]       out_q;
    logic               out_valid_q;

    logic [7:0]         cur_byte;
    logic [7:0]         sb_out;
    logic [127:0]       st_d;
    logic [127:0]       shifted;

    assign bus.in_ready  = (state_q == IDLE) && bus.enable;
    assign bus.OUT       = out_q;
    assign bus.out_valid = out_valid_q;

    // Only one S-box: the byte addressed by cnt_q is muxed in, looked up, and written back.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) == cnt_q) cur_byte = st_q[127-8*i -: 8];
        end
        sb_out = SBOX[cur_byte];
        st_d   = st_q;
        for (int i = 0; i < 16; i++) begin
            if (4'(i) == cnt_q) st_d[127-8*i -: 8] = sb_out;
        end
    end

    // Output byte (r,c) takes state byte (r,(c+r) mod 4); byte index is 4*col+row.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            key_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (!bus.enable) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        st_q    <= bus.IN;
                        key_q   <= bus.KEY;
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    st_q  <= st_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_q <= DONE;
                end
                DONE: begin
                    out_q       <= shifted ^ key_q;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/round_final_enc.md
Name: round_final_enc

Overview:
- Final encryption round of AES-128/256: SubBytes, then ShiftRows, then AddRoundKey with the last round key. MixColumns is not applied.
- Sits at the tail of the encryption datapath, feeding ciphertext out. It is the encryption-side counterpart of the decryption entry round.
- Area-reduced, byte-serial implementation: one S-box lookup per cycle, sequenced by an FSM, with a valid/ready handshake on input and a single-cycle valid pulse on output.

Parameters:
- BLOCK_LENGTH, 128, state/key width in bits. Only 128 is supported.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous active-low reset.
- IN  input  BLOCK_LENGTH  round input state. Byte i = IN[127-8i -: 8]; byte i is row i%4, column i/4.
- KEY  input  BLOCK_LENGTH  final round key, same byte order as IN.
- in_valid  input  1  IN/KEY valid this cycle.
- in_ready  output  1  block can accept a new IN/KEY.
- enable  input  1  round on/off; 0 forces synchronous idle.
- OUT  output  BLOCK_LENGTH  ciphertext, registered.
- out_valid  output  1  one-cycle pulse: OUT holds a new result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE;
  - OUT=0, out_valid=0, byte counter=0, internal state and key registers=0.
- in_ready is combinational: (state==IDLE) && enable.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - On an edge with in_valid && in_ready, latch IN into the state register and KEY into the key register, clear the counter, and go to SUB.
  - Otherwise hold.
- SUB:
  - Each edge replaces byte[cnt] with Sbox(byte[cnt]) and increments cnt.
  - The edge with cnt==15 goes to DONE.
  - This state lasts exactly 16 cycles.
- DONE (one cycle):
  - OUT <= ShiftRows(state) XOR key. ShiftRows output byte (r,c) = state byte (r,(c+r) mod 4).
  - out_valid <= 1; go to IDLE.
- out_valid:
  - Cleared on every edge where DONE is not being exited.
  - High for exactly one cycle.
  - OUT holds its value until the next DONE, enable=0, or reset.
- Latency, with the accept edge as E0:
  - SUB edges are E1..E16;
  - OUT and out_valid are updated at E17.
  - The next accept is possible at E18 (in_ready high after E17).
  - Throughput is one block per 18 cycles.
- in_valid outside IDLE is ignored; nothing is queued. Upstream must hold in_valid until in_ready.
- IN/KEY changes after acceptance do not affect the block in flight.
- enable=0 (synchronous, takes priority over everything except reset):
  - state=IDLE, OUT=0, out_valid=0, cnt=0.
  - The block in flight is discarded.
- Reset mid-operation: immediate return to reset values; no partial output.
- S-box: standard FIPS-197 forward S-box, 256-entry constant lookup, combinational. This is the only S-box instance in the block.

Test Plan:
- Reset/idle: assert rst=0 mid-SUB -> OUT=0, out_valid=0, in_ready=1 immediately after rst=1 with enable=1.
- Zero vector: IN=0, KEY=0 -> at E17 OUT=63636363636363636363636363636363, out_valid=1 for one cycle.
- Key only: IN=0, KEY=all-ones -> OUT=9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c9c.
- FIPS-197 Appendix B round 10:
  - IN=eb40f21e592e38848ba113e71bc342d2, KEY=d014f9a8c9ee2589e13f0cc8b6630ca6 -> OUT=3925841d02dc09fbdc118597196a0b32.
- Handshake/throughput:
  - Hold in_valid high for two blocks -> second accepted exactly at E18.
  - IN changes during SUB do not alter the result.
  - Two out_valid pulses 18 cycles apart.
- Enable abort: drop enable at E8 for one cycle -> OUT=0, out_valid never pulses for that block, in_ready returns next cycle.
